// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: FSM state encoding, NOP word and instruction field positions.
// FETCH_MISALIGN_TRAP_EN adds the FAULT state.
package rv32i_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC
`ifdef FETCH_MISALIGN_TRAP_EN
        , ST_FAULT
`endif
    } fetch_state_t;

    // addi x0,x0,0
    localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;

    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned FUN3_MSB   = 14;
    localparam int unsigned FUN3_LSB   = 12;
    localparam int unsigned FUN7_BIT   = 30;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: PC register, +4 adder, redirect mux and target alignment check.
// FETCH_MISALIGN_TRAP_EN exposes align_fault and loads an unaligned target unmodified.
module pc_counter #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        next_sel,
    input  logic [31:0] target_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        align_fault,
`endif
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] next_pc;

    // 32-bit add wraps 32'hFFFF_FFFC to 0 with no carry kept
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (next_sel) begin
            next_pc = target_pc & ~32'd3;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign align_fault = next_sel && (target_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (advance) begin
            pc <= align_fault ? target_pc : next_pc;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (advance) begin
            pc <= next_pc;
        end
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: IDLE -> FETCH -> EXEC loop, one instruction per EXEC exit.
// FETCH_MISALIGN_TRAP_EN enables the sticky misaligned-target FAULT state and misalign port.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = RV_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_valid,
    input  logic [31:0] im_rdata,
    input  logic        next_sel,
    input  logic [31:0] target_pc,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [6:0]  opcode,
    output logic [2:0]  fun3,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fun7,
    output logic        misalign
`else
    output logic        fun7
`endif
);

    fetch_state_t state;
    logic         advance;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         align_fault;
`endif

    assign advance = (state == ST_EXEC) && !stall;

    pc_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .next_sel    (next_sel),
        .target_pc   (target_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .align_fault (align_fault),
`endif
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    assign im_addr = pc;
    assign opcode  = inst[OPCODE_MSB:OPCODE_LSB];
    assign fun3    = inst[FUN3_MSB:FUN3_LSB];
    assign fun7    = inst[FUN7_BIT];

    // im_req and inst_valid are registered alongside state so they never glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            im_req     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state  <= ST_FETCH;
                    im_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (im_valid) begin
                        inst       <= im_rdata;
                        state      <= ST_EXEC;
                        im_req     <= 1'b0;
                        inst_valid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (align_fault) begin
                            state    <= ST_FAULT;
                            misalign <= 1'b1;
                        end else begin
                            state  <= ST_FETCH;
                            im_req <= 1'b1;
                        end
`else
                        state  <= ST_FETCH;
                        im_req <= 1'b1;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
`endif
                default: begin
                    state  <= ST_IDLE;
                    im_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a phase-level model.
// Build with FETCH_MISALIGN_TRAP_EN to also exercise the misaligned-target fault.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_valid;
    logic [31:0] im_rdata;
    logic        next_sel;
    logic [31:0] target_pc;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic        inst_valid;
    logic [6:0]  opcode;
    logic [2:0]  fun3;
    logic        fun7;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_valid   (im_valid),
        .im_rdata   (im_rdata),
        .next_sel   (next_sel),
        .target_pc  (target_pc),
        .stall      (stall),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .inst       (inst),
        .inst_valid (inst_valid),
        .opcode     (opcode),
        .fun3       (fun3),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fun7       (fun7),
        .misalign   (misalign)
`else
        .fun7       (fun7)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Model: has a fetch been launched, is an instruction currently presented, and which one
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_started;
    logic        m_holding;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("im_req",     32'(im_req),     32'(m_started && !m_holding));
        check("im_addr",    im_addr,         m_pc);
        check("pc",         pc,              m_pc);
        check("pc_plus4",   pc_plus4,        m_pc + 32'd4);
        check("inst_valid", 32'(inst_valid), 32'(m_holding));
        check("inst",       inst,            m_inst);
        check("opcode",     32'(opcode),     32'(m_inst[6:0]));
        check("fun3",       32'(fun3),       32'(m_inst[14:12]));
        check("fun7",       32'(fun7),       32'(m_inst[30]));
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign",   32'(misalign),   32'd0);
`endif
    endtask

    task automatic model_reset();
        m_pc      = 32'h0000_0000;
        m_inst    = 32'h0000_0013;
        m_started = 1'b0;
        m_holding = 1'b0;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check at the falling edge
    task automatic cyc(input logic v, input logic [31:0] d, input logic s,
                       input logic st, input logic [31:0] t);
        im_valid  = v;
        im_rdata  = d;
        next_sel  = s;
        stall     = st;
        target_pc = t;
        @(posedge clk);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_holding) begin
            if (v) begin
                m_inst    = d;
                m_holding = 1'b1;
            end
        end else if (!st) begin
            m_pc      = s ? {t[31:2], 2'b00} : m_pc + 32'd4;
            m_holding = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    // Fetch the given word (in one cycle) and leave it in execute
    task automatic fetch_one(input logic [31:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic retire(input logic s, input logic [31:0] t);
        cyc(1'b0, 32'h0, s, 1'b0, t);
    endtask

    logic [31:0] rt;

    initial begin
        rst = 1'b0; im_valid = 1'b0; im_rdata = '0; next_sel = 1'b0; stall = 1'b0; target_pc = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_inst", inst, 32'h0000_0013);

        // First instruction: memory answers immediately
        cyc(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        check("c1_req",  32'(im_req), 32'd1);
        check("c1_addr", im_addr, 32'h0);
        fetch_one(32'h0050_0093);
        check("c2_ivalid", 32'(inst_valid), 32'd1);
        check("c2_opcode", 32'(opcode), 32'h13);
        check("c2_fun3",   32'(fun3), 32'h0);
        retire(1'b0, 32'h0);

        // Slow memory: request and address must hold for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0080);
            check("wait_req",    32'(im_req), 32'd1);
            check("wait_addr",   im_addr, 32'h4);
            check("wait_ivalid", 32'(inst_valid), 32'd0);
        end
        fetch_one(32'h4000_5033);
        retire(1'b0, 32'h0);
        fetch_one(32'h00A5_8593);

        // Stall at pc=8 with a pending redirect and a stray memory strobe
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0100);
            check("stall_pc",     pc, 32'h8);
            check("stall_inst",   inst, 32'h00A5_8593);
            check("stall_ivalid", 32'(inst_valid), 32'd1);
            check("stall_req",    32'(im_req), 32'd0);
        end
        retire(1'b1, 32'h0000_0010);
        check("redir_after_stall", im_addr, 32'h10);

        fetch_one(32'h0000_006F);
        retire(1'b1, 32'h0000_0040);
        check("redir_40", im_addr, 32'h40);
        fetch_one(32'h0000_0013);
        retire(1'b1, 32'h0000_0010);
        fetch_one(32'h0000_0013);
        retire(1'b0, 32'h0000_0040);
        check("seq_14", im_addr, 32'h14);

        // Wrap-around of the sequential PC
        fetch_one(32'h0000_0013);
        retire(1'b1, 32'hFFFF_FFFC);
        fetch_one(32'h0000_0013);
        check("wrap_plus4", pc_plus4, 32'h0);
        retire(1'b0, 32'h0);
        check("wrap_addr", im_addr, 32'h0);

        // Reset while a fetch is outstanding; the strobe after release is ignored for one cycle
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        im_valid = 1'b1;
        im_rdata = 32'hCAFE_0001;
        do_reset();
        cyc(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0);
        check("post_rst_inst", inst, 32'h0000_0013);
        check("post_rst_iv",   32'(inst_valid), 32'd0);
        fetch_one(32'hCAFE_0001);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            rt[1:0] = 2'b00;
`endif
            cyc(($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 9) < 3), rt);
        end

        // Unaligned redirect target
        while (!m_holding) fetch_one(32'h0000_0013);
`ifdef FETCH_MISALIGN_TRAP_EN
        im_valid = 1'b0; next_sel = 1'b1; stall = 1'b0; target_pc = 32'h0000_0042;
        @(posedge clk);
        @(negedge clk);
        next_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            im_valid = 1'b1;
            check("fault_misalign", 32'(misalign), 32'd1);
            check("fault_req",      32'(im_req), 32'd0);
            check("fault_pc",       pc, 32'h0000_0042);
            check("fault_ivalid",   32'(inst_valid), 32'd0);
            @(negedge clk);
        end
        do_reset();
`else
        retire(1'b1, 32'h0000_0042);
        check("unaligned_addr", im_addr, 32'h40);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), instruction register value on reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 im_req  output  1  instruction memory request, held until im_valid.
REQ-006 im_addr  output  32  word-aligned fetch address; equals pc.
REQ-007 im_valid  input  1  instruction memory response strobe; sampled only while im_req=1.
REQ-008 im_rdata  input  32  instruction word, qualified by im_valid.
REQ-009 next_sel  input  1  1 = next PC is target_pc (taken branch/jal), 0 = pc+4; sampled in EXEC only.
REQ-010 target_pc  input  32  redirect target from datapath.
REQ-011 stall  input  1  holds current instruction in EXEC.
REQ-012 pc  output  32  address of instruction in inst.
REQ-013 pc_plus4  output  32  pc+4, combinational, for jal link write.
REQ-014 inst  output  32  latched instruction word.
REQ-015 inst_valid  output  1  inst valid for decode/execute this cycle.
REQ-016 opcode  output  7  inst[6:0]; fun3  output  3  inst[14:12]; fun7  output  1  inst[30] — feeds controlunit directly.
REQ-017 misalign  output  1  misaligned-target fault flag (present only with FETCH_MISALIGN_TRAP_EN).

Function
REQ-018 FSM states: IDLE, FETCH, EXEC (plus FAULT with macro).
REQ-019 IDLE -> FETCH unconditionally on first clock after reset release.
REQ-020 FETCH: im_req=1, im_addr=pc; on im_valid=1 latch im_rdata into inst, go EXEC next cycle.
REQ-021 FETCH without im_valid: remain, im_req and im_addr stable (no retraction).
REQ-022 EXEC: inst_valid=1, im_req=0; stall=1 holds state, pc, inst.
REQ-023 EXEC with stall=0: pc <= next_sel ? {target_pc[31:2],2'b00} : pc+4, go FETCH; one instruction retires per EXEC exit.
REQ-024 Minimum latency: 2 cycles per instruction (FETCH with same-cycle im_valid, then EXEC).
REQ-025 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-026 im_valid outside FETCH ignored; inst unchanged.
REQ-027 next_sel and stall both 1 in EXEC: stall wins, redirect re-sampled when stall drops.
REQ-028 inst_valid=0 in IDLE, FETCH, FAULT.

Reset
REQ-029 rst=0 asynchronously forces state=IDLE, pc=RESET_PC, inst=NOP_INST, inst_valid=0, im_req=0, misalign=0.
REQ-030 Reset asserted mid-FETCH abandons request; pending im_valid after release is ignored until new FETCH.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN: defined -> redirect in EXEC with target_pc[1:0]!=0 enters FAULT, misalign=1 sticky, im_req=0, pc=target_pc unmodified, exit only by reset.
REQ-032 Macro undefined: target_pc[1:0] silently forced to 00, no FAULT state, misalign port absent.

Structure
REQ-033 Package rv32i_pkg holds FSM state enum, NOP_INST constant, opcode field bit ranges.
REQ-034 One sub-module pc_counter: PC register, +4 adder, redirect mux, alignment check.

Verification
REQ-035 Reset release, im_valid=1 immediately, rdata=32'h0050_0093 -> im_addr=0 in cycle 1, inst_valid=1 cycle 2, opcode=7'h13, fun3=0.
REQ-036 Memory delays im_valid 3 cycles -> im_req/im_addr=0x4 stable all 3 cycles, inst_valid only after valid.
REQ-037 EXEC at pc=0x10, next_sel=1, target_pc=0x40 -> next im_addr=0x40; next_sel=0 -> 0x14.
REQ-038 stall=1 for 4 cycles in EXEC at pc=0x8 -> inst, pc held, inst_valid=1 throughout, im_req=0.
REQ-039 pc=32'hFFFF_FFFC, next_sel=0 -> next im_addr=0x0.
REQ-040 Macro defined, target_pc=0x42 -> FAULT, misalign=1, im_req=0 until rst; macro undefined -> im_addr=0x40.
